// File: rtl/unibus_dma.sv
// Unibus NPR bus master: lets the ARM run single DATI/DATO/DATOB cycles.
// Arbitrates via NPR/NPG/SACK, then drives address/control/data and MSYN, and finishes the cycle against whichever slave answers.
module unibus_dma #(
    parameter int DESKEW  = 15,
    parameter int TIMEOUT = 1000
) (
    input  logic        CLOCK,
    input  logic        powerup,
    input  logic        businit,
    input  logic        armwrite,
    input  logic [2:0]  armraddr,
    input  logic [2:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    input  logic [17:0] a_in_h,
    input  logic [15:0] d_in_h,
    input  logic        ssyn_in_h,
    input  logic        pb_in_h,
    input  logic        bbsy_in_h,
    input  logic        npg_in_h,
    input  logic        sack_in_h,
    output logic [17:0] a_out_h,
    output logic [1:0]  c_out_h,
    output logic [15:0] d_out_h,
    output logic        msyn_out_h,
    output logic        npr_out_h,
    output logic        sack_out_h,
    output logic        bbsy_out_h
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_REQ     = 4'd1,
        ST_GRANT   = 4'd2,
        ST_WAITBUS = 4'd3,
        ST_ADDR    = 4'd4,
        ST_MSYN    = 4'd5,
        ST_SETTLE  = 4'd6,
        ST_ENDW    = 4'd7,
        ST_RELEASE = 4'd8
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  func_q, func_d;
    logic        flag_to_q, flag_to_d;
    logic        flag_pe_q, flag_pe_d;
    logic        flag_ab_q, flag_ab_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [7:0]  count_q, count_d;
    logic [15:0] cnt_q, cnt_d;
    logic [17:0] a_q, a_d;
    logic [1:0]  c_q, c_d;
    logic [15:0] d_q, d_d;
    logic        msyn_q, msyn_d;
    logic        npr_q, npr_d;
    logic        sack_q, sack_d;
    logic        bbsy_q, bbsy_d;

    logic        idle_s;
    logic        wr1_s;
    logic        wr2_s;
    logic        tmo_s;
    logic        abort_s;
    logic        done_s;
    logic        unused_s;

    assign unused_s = ^{a_in_h, sack_in_h, armwdata[28:18], armwdata[31:16]};

    // Next-state, register-file update and bus drive for the single-cycle master.
    always_comb begin
        idle_s  = (state_q == ST_IDLE) && (func_q == 3'd0);
        wr1_s   = armwrite && idle_s && (armwaddr == 3'd1);
        wr2_s   = armwrite && idle_s && (armwaddr == 3'd2);
        abort_s = businit && (state_q != ST_IDLE);
        tmo_s   = 1'b0;
        done_s  = 1'b0;

        state_d   = state_q;
        func_d    = wr1_s ? armwdata[31:29] : func_q;
        addr_d    = wr1_s ? armwdata[17:0]  : addr_q;
        data_d    = wr2_s ? armwdata[15:0]  : data_q;
        flag_pe_d = wr1_s ? 1'b0 : flag_pe_q;
        count_d   = count_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        c_d       = c_q;
        d_d       = d_q;
        msyn_d    = msyn_q;
        npr_d     = npr_q;
        sack_d    = sack_q;
        bbsy_d    = bbsy_q;

        case (state_q)
            ST_IDLE: begin
                if (func_q != 3'd0) begin
                    state_d = ST_REQ;
                    npr_d   = 1'b1;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (npg_in_h) begin
                    state_d = ST_GRANT;
                    sack_d  = 1'b1;
                    npr_d   = 1'b0;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    tmo_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_GRANT: begin
                state_d = npg_in_h ? ST_GRANT : ST_WAITBUS;
            end
            ST_WAITBUS: begin
                if (!bbsy_in_h && !ssyn_in_h) begin
                    state_d = ST_ADDR;
                    bbsy_d  = 1'b1;
                    sack_d  = 1'b0;
                    cnt_d   = 16'd0;
                    d_d     = (func_q == 3'd4) ? 16'd0 : data_q;
                    // Only DATOB-high forces the odd byte address; everything else is word aligned.
                    case (func_q)
                        3'd4:    begin c_d = 2'b00; a_d = {addr_q[17:1], 1'b0}; end
                        3'd3:    begin c_d = 2'b10; a_d = {addr_q[17:1], 1'b0}; end
                        3'd2:    begin c_d = 2'b11; a_d = {addr_q[17:1], 1'b1}; end
                        3'd1:    begin c_d = 2'b11; a_d = {addr_q[17:1], 1'b0}; end
                        default: begin c_d = 2'b00; a_d = {addr_q[17:1], 1'b0}; end
                    endcase
                end else begin
                    state_d = ST_WAITBUS;
                end
            end
            ST_ADDR: begin
                if (cnt_q == 16'(DESKEW - 1)) begin
                    state_d = ST_MSYN;
                    msyn_d  = 1'b1;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_MSYN: begin
                if (ssyn_in_h) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 16'd0;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    tmo_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 16'(DESKEW - 1)) begin
                    state_d = ST_ENDW;
                    msyn_d  = 1'b0;
                    cnt_d   = 16'd0;
                    if (func_q == 3'd4) begin
                        data_d    = d_in_h;
                        flag_pe_d = flag_pe_q | pb_in_h;
                    end else begin
                        data_d    = data_q;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_ENDW: begin
                if (!ssyn_in_h) begin
                    state_d = ST_RELEASE;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    tmo_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RELEASE: begin
                done_s = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        flag_ab_d = wr1_s ? 1'b0 : (flag_ab_q | abort_s);
        flag_to_d = wr1_s ? 1'b0 : (flag_to_q | (tmo_s & ~abort_s));

        // Abort, timeout and normal completion all leave the bus undriven and the block idle.
        if (abort_s || tmo_s || done_s) begin
            state_d = ST_IDLE;
            func_d  = 3'd0;
            cnt_d   = 16'd0;
            a_d     = 18'd0;
            c_d     = 2'b00;
            d_d     = 16'd0;
            msyn_d  = 1'b0;
            npr_d   = 1'b0;
            sack_d  = 1'b0;
            bbsy_d  = 1'b0;
            count_d = (done_s && !abort_s) ? count_q + 8'd1 : count_q;
        end else begin
            count_d = count_q;
        end
    end

    // State and register flops with synchronous power-up clear.
    always_ff @(posedge CLOCK) begin
        if (powerup) begin
            state_q   <= ST_IDLE;
            func_q    <= 3'd0;
            flag_to_q <= 1'b0;
            flag_pe_q <= 1'b0;
            flag_ab_q <= 1'b0;
            addr_q    <= 18'd0;
            data_q    <= 16'd0;
            count_q   <= 8'd0;
            cnt_q     <= 16'd0;
            a_q       <= 18'd0;
            c_q       <= 2'b00;
            d_q       <= 16'd0;
            msyn_q    <= 1'b0;
            npr_q     <= 1'b0;
            sack_q    <= 1'b0;
            bbsy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            func_q    <= func_d;
            flag_to_q <= flag_to_d;
            flag_pe_q <= flag_pe_d;
            flag_ab_q <= flag_ab_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            count_q   <= count_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            c_q       <= c_d;
            d_q       <= d_d;
            msyn_q    <= msyn_d;
            npr_q     <= npr_d;
            sack_q    <= sack_d;
            bbsy_q    <= bbsy_d;
        end
    end

    // ARM register read mux.
    always_comb begin
        case (armraddr)
            3'd0:    armrdata = 32'h444D1001;
            3'd1:    armrdata = {func_q, flag_to_q, flag_pe_q, flag_ab_q, 8'd0, addr_q};
            3'd2:    armrdata = {count_q, 8'd0, data_q};
            3'd3:    armrdata = {28'd0, state_q};
            default: armrdata = 32'hDEADBEEF;
        endcase
    end

    assign a_out_h    = a_q;
    assign c_out_h    = c_q;
    assign d_out_h    = d_q;
    assign msyn_out_h = msyn_q;
    assign npr_out_h  = npr_q;
    assign sack_out_h = sack_q;
    assign bbsy_out_h = bbsy_q;

endmodule

// File: tb/tb_unibus_dma.sv
// Directed bench for unibus_dma with a small arbiter and memory-slave responder.
module tb_unibus_dma;

    localparam int DESKEW  = 15;
    localparam int TIMEOUT = 1000;

    logic        CLOCK = 1'b0;
    logic        powerup = 1'b1;
    logic        businit = 1'b0;
    logic        armwrite = 1'b0;
    logic [2:0]  armraddr = 3'd0;
    logic [2:0]  armwaddr = 3'd0;
    logic [31:0] armwdata = 32'd0;
    logic [31:0] armrdata;
    logic [17:0] a_in_h = 18'd0;
    logic [15:0] d_in_h = 16'd0;
    logic        ssyn_in_h = 1'b0;
    logic        pb_in_h = 1'b0;
    logic        bbsy_in_h = 1'b0;
    logic        npg_in_h = 1'b0;
    logic        sack_in_h = 1'b0;
    logic [17:0] a_out_h;
    logic [1:0]  c_out_h;
    logic [15:0] d_out_h;
    logic        msyn_out_h, npr_out_h, sack_out_h, bbsy_out_h;

    logic        slave_en = 1'b1;
    logic        grant_en = 1'b1;
    logic        pb_force = 1'b0;
    logic [15:0] mem_val = 16'd0;

    int n_cmp = 0;
    int n_bad = 0;

    unibus_dma #(.DESKEW(DESKEW), .TIMEOUT(TIMEOUT)) dut (
        .CLOCK(CLOCK), .powerup(powerup), .businit(businit),
        .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
        .armwdata(armwdata), .armrdata(armrdata),
        .a_in_h(a_in_h), .d_in_h(d_in_h), .ssyn_in_h(ssyn_in_h),
        .pb_in_h(pb_in_h), .bbsy_in_h(bbsy_in_h), .npg_in_h(npg_in_h),
        .sack_in_h(sack_in_h),
        .a_out_h(a_out_h), .c_out_h(c_out_h), .d_out_h(d_out_h),
        .msyn_out_h(msyn_out_h), .npr_out_h(npr_out_h),
        .sack_out_h(sack_out_h), .bbsy_out_h(bbsy_out_h)
    );

    always #5 CLOCK = ~CLOCK;

    // Arbiter grants one cycle after NPR; slave answers SSYN one cycle after MSYN and drops it one cycle after.
    always @(posedge CLOCK) begin
        #1;
        ssyn_in_h = slave_en && msyn_out_h;
        d_in_h    = ssyn_in_h ? mem_val : 16'd0;
        pb_in_h   = pb_force && ssyn_in_h;
        npg_in_h  = grant_en && npr_out_h && !sack_out_h;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic arm_wr(input logic [2:0] idx, input logic [31:0] val);
        armwaddr = idx;
        armwdata = val;
        armwrite = 1'b1;
        step();
        armwrite = 1'b0;
    endtask

    task automatic rd(input logic [2:0] idx, output logic [31:0] v);
        armraddr = idx;
        #1;
        v = armrdata;
    endtask

    function automatic logic sel(input int w);
        case (w)
            0:       return bbsy_out_h;
            1:       return msyn_out_h;
            default: return npr_out_h;
        endcase
    endfunction

    task automatic wait_out(input string tag, input int w, input logic lvl, output int n);
        n = 0;
        while (sel(w) !== lvl && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) check_eq({tag, "_wait"}, 32'(sel(w)), 32'(lvl));
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] v;
        int n;
        n = 0;
        rd(3'd1, v);
        while (v[31:29] != 3'd0 && n < 3000) begin
            step();
            n++;
            rd(3'd1, v);
        end
        check_eq({tag, "_done"}, {29'd0, v[31:29]}, 32'd0);
    endtask

    task automatic check_idle_outs(input string tag);
        check_eq({tag, "_a"}, {14'd0, a_out_h}, 32'd0);
        check_eq({tag, "_ctl"}, {10'd0, c_out_h, d_out_h, msyn_out_h, npr_out_h, sack_out_h, bbsy_out_h}, 32'd0);
    endtask

    logic [31:0] v;
    int n;

    initial begin
        repeat (3) step();
        powerup = 1'b0;
        step();

        check_idle_outs("rst");
        rd(3'd0, v); check_eq("rst_id", v, 32'h444D1001);
        rd(3'd1, v); check_eq("rst_r1", v, 32'd0);
        rd(3'd2, v); check_eq("rst_r2", v, 32'd0);
        rd(3'd3, v); check_eq("rst_r3", v, 32'd0);
        rd(3'd6, v); check_eq("rst_r6", v, 32'hDEADBEEF);

        // DATI 000100 returning 012345 with good parity
        mem_val = 16'o012345;
        arm_wr(3'd1, {3'd4, 11'd0, 18'o000100});
        wait_out("dati_bbsy", 0, 1'b1, n);
        check_eq("dati_a", {14'd0, a_out_h}, {14'd0, 18'o000100});
        check_eq("dati_cd", {14'd0, c_out_h, d_out_h}, 32'd0);
        wait_done("dati");
        rd(3'd2, v); check_eq("dati_r2", v, {8'd1, 8'd0, 16'o012345});
        rd(3'd1, v); check_eq("dati_r1", v, {14'd0, 18'o000100});
        check_idle_outs("dati_end");

        // DATOB high at 001000, check deskew before MSYN
        mem_val = 16'd0;
        arm_wr(3'd2, 32'h0000AB00);
        arm_wr(3'd1, {3'd2, 11'd0, 18'o001000});
        wait_out("datob_bbsy", 0, 1'b1, n);
        check_eq("datob_a", {14'd0, a_out_h}, {14'd0, 18'o001001});
        check_eq("datob_c", {30'd0, c_out_h}, 32'd3);
        check_eq("datob_d", {16'd0, d_out_h}, 32'h0000AB00);
        check_eq("datob_msyn0", {31'd0, msyn_out_h}, 32'd0);
        wait_out("datob_msyn", 1, 1'b1, n);
        check_eq("datob_deskew", n, DESKEW);
        wait_done("datob");
        rd(3'd2, v); check_eq("datob_r2", v, {8'd2, 8'd0, 16'hAB00});

        // DATI to nonexistent 160000: MSYN timeout
        slave_en = 1'b0;
        arm_wr(3'd1, {3'd4, 11'd0, 18'o160000});
        wait_out("nxm_msyn1", 1, 1'b1, n);
        wait_out("nxm_msyn0", 1, 1'b0, n);
        check_eq("nxm_tmo_cycles", n, TIMEOUT);
        check_idle_outs("nxm_end");
        rd(3'd1, v); check_eq("nxm_r1", v, {3'd0, 1'b1, 2'b00, 8'd0, 18'o160000});
        rd(3'd2, v); check_eq("nxm_count", {24'd0, v[31:24]}, 32'd2);
        slave_en = 1'b1;

        // No grant: REQ timeout
        grant_en = 1'b0;
        arm_wr(3'd1, {3'd4, 11'd0, 18'o000200});
        wait_out("nog_npr1", 2, 1'b1, n);
        wait_out("nog_npr0", 2, 1'b0, n);
        check_eq("nog_tmo_cycles", n, TIMEOUT);
        rd(3'd1, v); check_eq("nog_r1", v, {3'd0, 1'b1, 2'b00, 8'd0, 18'o000200});
        rd(3'd2, v); check_eq("nog_count", {24'd0, v[31:24]}, 32'd2);
        grant_en = 1'b1;

        // businit during MSYN
        slave_en = 1'b0;
        arm_wr(3'd2, 32'h00001234);
        arm_wr(3'd1, {3'd3, 11'd0, 18'o000010});
        wait_out("init_msyn", 1, 1'b1, n);
        repeat (3) step();
        businit = 1'b1;
        step();
        check_idle_outs("init_outs");
        businit = 1'b0;
        rd(3'd1, v); check_eq("init_r1", v, {3'd0, 1'b0, 1'b0, 1'b1, 8'd0, 18'o000010});
        rd(3'd3, v); check_eq("init_state", v, 32'd0);
        slave_en = 1'b1;
        mem_val = 16'o007070;
        arm_wr(3'd1, {3'd4, 11'd0, 18'o000100});
        wait_done("init_after");
        rd(3'd1, v); check_eq("init_after_r1", v, {14'd0, 18'o000100});
        rd(3'd2, v); check_eq("init_after_r2", v, {8'd3, 8'd0, 16'o007070});

        // DATI with bad parity
        pb_force = 1'b1;
        mem_val = 16'o054321;
        arm_wr(3'd1, {3'd4, 11'd0, 18'o000100});
        wait_done("par");
        rd(3'd1, v); check_eq("par_r1", v, {3'd0, 1'b0, 1'b1, 1'b0, 8'd0, 18'o000100});
        rd(3'd2, v); check_eq("par_r2", v, {8'd4, 8'd0, 16'o054321});
        pb_force = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/unibus_dma.md
# unibus_dma

Unibus NPR bus master letting the ARM perform single DATI/DATO/DATOB cycles on the Unibus: it arbitrates for the bus, drives address/control/data and MSYN, and completes the cycle against whatever slave answers (main memory, boot ROM, M7850-like control register, or real devices). It is the upstream master feeding the memory slave: its a/c/d/msyn outputs are OR'd into the same Unibus signals the memory block consumes, and the memory block's ssyn/d/pb outputs come back here. The ARM register interface matches the other ARM-visible blocks (3-bit register address, 32-bit data).

## Interface
- DESKEW, 15: cycles address/data must be stable before MSYN asserts, and read-data settle delay after SSYN (150 ns at 100 MHz).
- TIMEOUT, 1000: cycles allowed for each wait (grant, SSYN assert, SSYN negate) before aborting (10 µs).
- CLOCK  in  1  system clock; all logic on rising edge.
- powerup  in  1  reset; synchronous, active-high.
- businit  in  1  Unibus INIT, or fpga off; aborts any cycle.
- armwrite  in  1  one-cycle ARM register write strobe.
- armraddr, armwaddr  in  3  ARM read/write register index.
- armwdata  in  32  ARM write data.
- armrdata  out  32  ARM read data (combinational from armraddr).
- a_in_h  in  18  (unused except debug; reserved).
- d_in_h  in  16  Unibus data (read data).
- ssyn_in_h, pb_in_h, bbsy_in_h, npg_in_h, sack_in_h  in  1  Unibus signals, asserted-high sense.
- a_out_h  out  18;  c_out_h  out  2;  d_out_h  out  16  Unibus drive.
- msyn_out_h, npr_out_h, sack_out_h, bbsy_out_h  out  1  Unibus drive.

## Operation
- Registers (armrdata for other indices = 32'hDEADBEEF):
  - 0 ro: 32'h444D1001 ('DM', 4 regs, version 001).
  - 1 rw: [31:29] func (4=DATI, 3=DATO word, 2=DATOB high, 1=DATOB low; nonzero = busy, self-clearing); [28] timeout; [27] parity error; [26] aborted by businit; [17:00] address. Write accepted only when idle; write clears [28:26].
  - 2 rw: [15:00] data (write data; read result replaces it). [31:24] ro count of completed cycles, mod 256. Writes ignored while busy.
  - 3 ro: [3:0] state (debug).
- Bus cycle encoding: func 4 → c=00, a=addr&~1; 3 → c=10, a=addr&~1; 2 → c=11, a=addr|1; 1 → c=11, a=addr&~1. d_out_h driven only for writes, else 0.
- States: IDLE → REQ (npr=1) on func≠0. REQ → GRANT when npg_in_h: sack=1, npr=0. GRANT → WAITBUS when ~npg_in_h. WAITBUS → ADDR when ~bbsy_in_h & ~ssyn_in_h & ~sack_in_h-from-others ignored: bbsy=1, sack=0, drive a/c/d, counter=0. ADDR → MSYN after DESKEW cycles: msyn=1. MSYN → SETTLE on ssyn_in_h. SETTLE: after DESKEW cycles, for DATI latch d_in_h to data and set [27] if pb_in_h; msyn=0 → ENDW. ENDW → RELEASE when ~ssyn_in_h. RELEASE: bbsy=0, a/c/d=0, count+1, func=0 → IDLE.
- Timeout: REQ, MSYN, ENDW each count; reaching TIMEOUT sets [28], drops all outputs, func=0, IDLE. Count not incremented on timeout or abort.
- businit in any non-IDLE state: all outputs 0 next cycle, [26]=1, func=0, IDLE. powerup: registers 0, IDLE.
- Write to reg 1 with func=0 only updates address/clears flags.

## Timing
- Reset values: all *_out_h = 0; func, flags, data, address, count = 0.
- ARM write visible in armrdata the following cycle; REQ entered the cycle after a func write.
- Min idle-to-idle (immediate grant, ssyn 1 cycle after msyn and drop 1 cycle after): ~2·DESKEW+7 cycles.
- a/c/d stable from ADDR entry through RELEASE; msyn never rises before DESKEW cycles of stable a/c/d.
- Simultaneous armwrite and state transition: register write wins only if idle; state machine unaffected otherwise.

## Test plan
- DATI 000100 with memory slave returning 012345 (good parity) -> reg2=012345, [27]=0, count=1, outputs all 0 after.
- DATOB high at 001000 data 0xAB00 -> a_out_h=001001, c=11, msyn rises exactly DESKEW cycles after a valid.
- DATI to nonexistent 160000 (no SSYN) -> [28]=1 after TIMEOUT cycles in MSYN, bbsy/msyn drop, func=0, count unchanged.
- npg never asserted -> timeout from REQ, npr drops.
- businit during MSYN -> next cycle outputs 0, [26]=1, IDLE; new func accepted after.
- DATI with pb_in_h=1 during SETTLE -> [27]=1, data still latched.
